// File: rtl/uc_control.sv
// Control unit for the single-cycle microcontroller datapath: instruction decode
// plus boot, halt, multi-cycle wait, debug pause/single-step and a retire counter.
module uc_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             run,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WCNT_W = 2;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_WAITING,
    ST_PAUSE,
    ST_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  cnt_q, cnt_d;
  logic               step_q;
  logic [CNT_W-1:0]   retired_q;
  logic               exec;
  logic               is_wait;
  logic               is_halt;

  assign is_wait = (Opcode[5:2] == 4'b0010);
  assign is_halt = (Opcode == 6'b001100);
  assign retired = retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      cnt_q     <= '0;
      step_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step;
      if (pc_en) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    s_inc   = 1'b0;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    Op      = 3'b000;
    pc_en   = 1'b0;
    halted  = 1'b0;

    case (state_q)
      ST_BOOT: state_d = run ? ST_RUN : ST_PAUSE;
      ST_RUN:  exec = 1'b1;
      ST_PAUSE: begin
        if (step && !step_q) exec = 1'b1;
        else if (run)        state_d = ST_RUN;
      end
      ST_WAITING: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WCNT_W'(1);
        end else begin
          pc_en   = 1'b1;
          state_d = run ? ST_RUN : ST_PAUSE;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_BOOT;
    endcase

    // Executing cycle: decode strobes and pick the sequencing outcome.
    if (exec) begin
      if (Opcode[5]) begin
        Op  = Opcode[4:2];
        we3 = 1'b1;
        wez = 1'b1;
      end else begin
        case (Opcode)
          6'b000000: begin
            we3   = 1'b1;
            s_inm = 1'b1;
          end
          6'b000100: s_inc = 1'b1;
          6'b000101: s_inc = z;
          6'b000110: s_inc = ~z;
          default:   ;
        endcase
      end

      if (is_halt) begin
        state_d = ST_HALT;
      end else if (is_wait) begin
        cnt_d   = Opcode[1:0];
        state_d = ST_WAITING;
      end else begin
        pc_en   = 1'b1;
        state_d = run ? ST_RUN : ST_PAUSE;
      end
    end
  end

endmodule

// File: tb/tb_uc_control.sv
// Self-checking bench for uc_control: decode table, wait/step/halt sequences,
// retire-counter wrap and asynchronous reset in the middle of a wait.
module tb_uc_control;

  localparam int unsigned CNT_W = 16;

  // Expected output word: {s_inc, s_inm, we3, wez, Op[2:0], pc_en, halted}
  localparam logic [8:0] E_ZERO = 9'b000000000;
  localparam logic [8:0] E_PC   = 9'b000000010;
  localparam logic [8:0] E_HALT = 9'b000000001;
  localparam logic [8:0] E_A010 = 9'b001101010;
  localparam logic [8:0] E_A111 = 9'b001111110;
  localparam logic [8:0] E_A000 = 9'b001100010;
  localparam logic [8:0] E_LI   = 9'b011000010;
  localparam logic [8:0] E_JMP  = 9'b100000010;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             z;
  logic             run;
  logic             step;
  logic             s_inc, s_inm, we3, wez, pc_en, halted;
  logic [2:0]       Op;
  logic [CNT_W-1:0] retired;

  int unsigned      n_chk = 0;
  int unsigned      n_pass = 0;
  logic [CNT_W-1:0] exp_ret;
  logic [8:0]       sb_q[$];

  typedef struct {
    logic [5:0] op;
    logic       zf;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[13];

  uc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .z(z), .run(run), .step(step),
    .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .Op(Op),
    .pc_en(pc_en), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [8:0] outs();
    return {s_inc, s_inm, we3, wez, Op, pc_en, halted};
  endfunction

  // One clock cycle: drive, queue the expectation, compare mid-cycle, advance.
  task automatic cyc(input string name, input logic [5:0] op, input logic zf,
                     input logic r, input logic st, input logic [8:0] exp);
    logic [8:0] e;
    Opcode = op; z = zf; run = r; step = st;
    sb_q.push_back(exp);
    @(negedge clk);
    e = sb_q.pop_front();
    chk(name, 32'(outs()), 32'(e));
    chk({name, "_retired"}, 32'(retired), 32'(exp_ret));
    if (e[1]) exp_ret = exp_ret + CNT_W'(1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'(E_ZERO));
    chk("reset_retired", 32'(retired), 32'd0);
    exp_ret = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{6'b101000, 1'b0, E_A010, "alu_010"};
    tbl[1]  = '{6'b111100, 1'b0, E_A111, "alu_111"};
    tbl[2]  = '{6'b100011, 1'b1, E_A000, "alu_000"};
    tbl[3]  = '{6'b000000, 1'b0, E_LI,   "li"};
    tbl[4]  = '{6'b000100, 1'b0, E_JMP,  "j"};
    tbl[5]  = '{6'b000101, 1'b1, E_JMP,  "jz_taken"};
    tbl[6]  = '{6'b000101, 1'b0, E_PC,   "jz_not"};
    tbl[7]  = '{6'b000110, 1'b0, E_JMP,  "jnz_taken"};
    tbl[8]  = '{6'b000110, 1'b1, E_PC,   "jnz_not"};
    tbl[9]  = '{6'b000001, 1'b0, E_PC,   "nop_01"};
    tbl[10] = '{6'b011111, 1'b1, E_PC,   "nop_1f"};
    tbl[11] = '{6'b001101, 1'b0, E_PC,   "nop_0d"};
    tbl[12] = '{6'b001111, 1'b0, E_PC,   "nop_0f"};

    reset = 1'b0; Opcode = '0; z = 1'b0; run = 1'b1; step = 1'b0;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_outs", 32'(outs()), 32'(E_ZERO));
    chk("por_retired", 32'(retired), 32'd0);
    reset = 1'b1;

    // Boot then first ALU instruction
    cyc("boot", 6'b101000, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("first_alu", 6'b101000, 1'b0, 1'b1, 1'b0, E_A010);

    foreach (tbl[i]) cyc(tbl[i].name, tbl[i].op, tbl[i].zf, 1'b1, 1'b0, tbl[i].exp);

    // WAIT 3: four low cycles, pc_en on the fifth
    cyc("wait3_run", 6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("wait3_c3",  6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("wait3_c2",  6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("wait3_c1",  6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("wait3_c0",  6'b001011, 1'b0, 1'b1, 1'b0, E_PC);

    // Pause with single steps on an LI stream; held step executes once
    cyc("pause_enter", 6'b000001, 1'b0, 1'b0, 1'b0, E_PC);
    cyc("pause_idle",  6'b000000, 1'b0, 1'b0, 1'b0, E_ZERO);
    cyc("step1",       6'b000000, 1'b0, 1'b0, 1'b1, E_LI);
    cyc("step1_held",  6'b000000, 1'b0, 1'b0, 1'b1, E_ZERO);
    cyc("step1_held2", 6'b000000, 1'b0, 1'b0, 1'b1, E_ZERO);
    cyc("step_low",    6'b000000, 1'b0, 1'b0, 1'b0, E_ZERO);
    cyc("step2",       6'b000000, 1'b0, 1'b0, 1'b1, E_LI);
    cyc("step2_held",  6'b000000, 1'b0, 1'b0, 1'b1, E_ZERO);
    cyc("step_low2",   6'b000000, 1'b0, 1'b0, 1'b0, E_ZERO);

    // Step into WAIT 1 from pause, returns to pause
    cyc("step_wait1",  6'b001001, 1'b0, 1'b0, 1'b1, E_ZERO);
    cyc("sw_c1",       6'b001001, 1'b0, 1'b0, 1'b1, E_ZERO);
    cyc("sw_c0",       6'b001001, 1'b0, 1'b0, 1'b0, E_PC);
    cyc("sw_paused",   6'b101000, 1'b0, 1'b0, 1'b0, E_ZERO);

    // Resume, then HALT; halt ignores run/step
    cyc("resume",      6'b101000, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("resumed_alu", 6'b101000, 1'b0, 1'b1, 1'b0, E_A010);
    cyc("halt_exec",   6'b001100, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("halted_a",    6'b101000, 1'b0, 1'b1, 1'b0, E_HALT);
    cyc("halted_b",    6'b000000, 1'b0, 1'b0, 1'b1, E_HALT);
    cyc("halted_c",    6'b000100, 1'b1, 1'b1, 1'b0, E_HALT);
    cyc("halted_d",    6'b000000, 1'b0, 1'b0, 1'b1, E_HALT);

    do_reset();

    // Retire counter wrap: 65535 NOPs then one more
    cyc("wrap_boot", 6'b000001, 1'b0, 1'b1, 1'b0, E_ZERO);
    repeat (65535) @(posedge clk);
    #1;
    chk("retired_max", 32'(retired), 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("retired_wrap", 32'(retired), 32'h0000_0000);
    exp_ret = '0;
    cyc("wrap_nop", 6'b000001, 1'b0, 1'b1, 1'b0, E_PC);

    // Reset in the middle of WAIT 3 (counter at 2)
    cyc("rw_run", 6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("rw_c3",  6'b001011, 1'b0, 1'b1, 1'b0, E_ZERO);
    reset = 1'b0;
    #1;
    chk("rw_reset_outs", 32'(outs()), 32'(E_ZERO));
    chk("rw_reset_retired", 32'(retired), 32'd0);
    exp_ret = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc("rw_boot",  6'b001001, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("rw_wait1", 6'b001001, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("rw_w_c1",  6'b001001, 1'b0, 1'b1, 1'b0, E_ZERO);
    cyc("rw_w_c0",  6'b001001, 1'b0, 1'b1, 1'b0, E_PC);
    cyc("rw_after", 6'b000000, 1'b0, 1'b1, 1'b0, E_LI);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
